// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the elastic pipeline stage.
// - ctrl_s / data_s: packed views of the ID/EX control and data vectors; wrappers bit-cast
//   these into the stage's flat control and data ports.
// - pipe_state_e: how many entries the stage currently holds.
package pipe_stage_skid_pkg;

  localparam int unsigned CtrlWidth = 32;
  localparam int unsigned DataWidth = 128;

  typedef struct packed {
    logic [7:0] alu_op;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
    logic [1:0] src_sel;
    logic       branch;
    logic       jump;
    logic [8:0] rsvd;
  } ctrl_s;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } data_s;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// One storage slot of the pipeline stage: a valid bit plus control/data payload.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   clear_i        synchronous clear (flush); beats load_i
//   load_i         write valid_i/ctrl_i/data_i this cycle
//   valid_i        valid bit to store; a 0 stores a bubble
//   ctrl_i/data_i  payload to store
//   valid_o, ctrl_o, data_o  stored contents
module pipe_stage_skid_entry #(
  parameter int unsigned     CtrlW     = 32,
  parameter int unsigned     DataW     = 128,
  parameter logic [CtrlW-1:0] CtrlClear = '0,
  parameter bit              DataClear = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             valid_i,
  input  logic [CtrlW-1:0] ctrl_i,
  input  logic [DataW-1:0] data_i,
  output logic             valid_o,
  output logic [CtrlW-1:0] ctrl_o,
  output logic [DataW-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [CtrlW-1:0] ctrl_q, ctrl_d;
  logic [DataW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = CtrlClear;
      if (DataClear) data_d = '0;
    end else if (load_i) begin
      valid_d = valid_i;
      ctrl_d  = valid_i ? ctrl_i : CtrlClear;
      if (valid_i) begin
        data_d = data_i;
      end else if (DataClear) begin
        data_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ctrl_q  <= CtrlClear;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Without DataClear the data flops carry no reset: only valid qualifies them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni && DataClear) begin
      data_q <= '0;
    end else if (rst_ni) begin
      data_q <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register with valid/ready handshake and optional skid entry.
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   flush_i                  drop every held and incoming entry
//   in_valid_i/in_ready_o    upstream handshake, in_ctrl_i/in_data_i payload
//   out_valid_o/out_ready_i  downstream handshake, out_ctrl_o/out_data_o head payload
//   occupancy_o              number of valid entries held
// Skid=0: one entry, in_ready_o depends combinationally on out_ready_i.
// Skid=1: head + skid entry, in_ready_o comes from flops only.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned      CtrlW     = CtrlWidth,
  parameter int unsigned      DataW     = DataWidth,
  parameter bit               Skid      = 1'b1,
  parameter logic [CtrlW-1:0] CtrlClear = '0,
  parameter bit               DataClear = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [CtrlW-1:0] in_ctrl_i,
  input  logic [DataW-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CtrlW-1:0] out_ctrl_o,
  output logic [DataW-1:0] out_data_o,
  output logic [1:0]       occupancy_o
);

  pipe_state_e state_q, state_d;

  logic             accept, issue;
  logic             main_load, main_from_skid, main_valid_in, main_valid;
  logic [CtrlW-1:0] main_ctrl_in, main_ctrl;
  logic [DataW-1:0] main_data_in, main_data;
  logic             skid_load, skid_valid_in, skid_valid;
  logic [CtrlW-1:0] skid_ctrl;
  logic [DataW-1:0] skid_data;

  if (Skid) begin : g_ready_reg
    assign in_ready_o = (state_q != StTwo);
  end else begin : g_ready_comb
    assign in_ready_o = ~main_valid | out_ready_i;
  end

  assign accept = in_valid_i & in_ready_o;
  assign issue  = main_valid & out_ready_i;

  // With Skid=0 an accept in StOne always coincides with an issue, so StTwo is unreachable.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_valid_in  = 1'b0;
    skid_load      = 1'b0;
    skid_valid_in  = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_load     = 1'b1;
          main_valid_in = 1'b1;
          state_d       = StOne;
        end
      end
      StOne: begin
        if (accept && issue) begin
          main_load     = 1'b1;
          main_valid_in = 1'b1;
        end else if (accept) begin
          skid_load     = 1'b1;
          skid_valid_in = 1'b1;
          state_d       = StTwo;
        end else if (issue) begin
          main_load = 1'b1;
          state_d   = StEmpty;
        end
      end
      StTwo: begin
        if (issue) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          main_valid_in  = 1'b1;
          skid_load      = 1'b1;
          state_d        = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush_i) state_d = StEmpty;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl_i;
  assign main_data_in = main_from_skid ? skid_data : in_data_i;

  pipe_stage_skid_entry #(
    .CtrlW    (CtrlW),
    .DataW    (DataW),
    .CtrlClear(CtrlClear),
    .DataClear(DataClear)
  ) u_main (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(flush_i),
    .load_i (main_load),
    .valid_i(main_valid_in),
    .ctrl_i (main_ctrl_in),
    .data_i (main_data_in),
    .valid_o(main_valid),
    .ctrl_o (main_ctrl),
    .data_o (main_data)
  );

  if (Skid) begin : g_skid
    pipe_stage_skid_entry #(
      .CtrlW    (CtrlW),
      .DataW    (DataW),
      .CtrlClear(CtrlClear),
      .DataClear(DataClear)
    ) u_skid (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clear_i(flush_i),
      .load_i (skid_load),
      .valid_i(skid_valid_in),
      .ctrl_i (in_ctrl_i),
      .data_i (in_data_i),
      .valid_o(skid_valid),
      .ctrl_o (skid_ctrl),
      .data_o (skid_data)
    );
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_ctrl  = CtrlClear;
    assign skid_data  = '0;
  end

  assign out_valid_o = main_valid;
  assign out_ctrl_o  = main_valid ? main_ctrl : CtrlClear;
  assign out_data_o  = main_data;
  assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three builds (Skid=1, Skid=0, Skid=1 without data clear) share
// one stimulus stream, each tracked by its own FIFO model.
module tb_pipe_stage_skid;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, out_ready;
  logic [31:0]  in_ctrl;
  logic [127:0] in_data;

  logic         irdy  [3];
  logic         ov    [3];
  logic [31:0]  octrl [3];
  logic [127:0] odata [3];
  logic [1:0]   occ   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(irdy[0]),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(ov[0]), .out_ready_i(out_ready),
    .out_ctrl_o(octrl[0]), .out_data_o(odata[0]), .occupancy_o(occ[0])
  );

  pipe_stage_skid #(.Skid(1'b0)) u_dut_s0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(irdy[1]),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(ov[1]), .out_ready_i(out_ready),
    .out_ctrl_o(octrl[1]), .out_data_o(odata[1]), .occupancy_o(occ[1])
  );

  pipe_stage_skid #(.DataClear(1'b0)) u_dut_nc (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(irdy[2]),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(ov[2]), .out_ready_i(out_ready),
    .out_ctrl_o(octrl[2]), .out_data_o(odata[2]), .occupancy_o(occ[2])
  );

  // Reference: a bounded FIFO per build; capacity 2 (skid) or 1 (single entry).
  int           mcnt  [3];
  logic [31:0]  mctrl [3][2];
  logic [127:0] mdata [3][2];
  bit           mclr  [3];
  bit           model_on = 1'b0;

  function automatic logic [127:0] mk_data(logic [31:0] c);
    return {~c, c, c + 32'd1, c[15:0], c[31:16]};
  endfunction

  function automatic logic m_irdy(int k);
    if (k == 1) return (mcnt[k] == 0) || out_ready;
    return mcnt[k] < 2;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic m_cmp(int k);
    chk($sformatf("d%0d_out_valid", k), ov[k], mcnt[k] > 0);
    chk($sformatf("d%0d_out_ctrl", k), octrl[k], (mcnt[k] > 0) ? mctrl[k][0] : 32'h0);
    chk($sformatf("d%0d_in_ready", k), irdy[k], m_irdy(k));
    chk($sformatf("d%0d_occupancy", k), occ[k], mcnt[k][1:0]);
    if (mcnt[k] > 0) chk($sformatf("d%0d_out_data", k), odata[k], mdata[k][0]);
    else if (mclr[k] && k != 2) chk($sformatf("d%0d_data_cleared", k), odata[k], 128'h0);
  endtask

  task automatic m_step(int k);
    bit iss, acc;
    iss = (mcnt[k] > 0) && out_ready;
    acc = in_valid && m_irdy(k);
    if (!rst_n || flush) begin
      mcnt[k] = 0;
      mclr[k] = 1'b1;
    end else begin
      if (iss) begin
        mctrl[k][0] = mctrl[k][1];
        mdata[k][0] = mdata[k][1];
        mcnt[k]--;
      end
      if (acc) begin
        mctrl[k][mcnt[k]] = in_ctrl;
        mdata[k][mcnt[k]] = in_data;
        mcnt[k]++;
        mclr[k] = 1'b0;
      end
    end
  endtask

  // One clock: compare at the falling edge, probe the ready path by toggling out_ready,
  // then advance the models at the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (model_on) for (int k = 0; k < 3; k++) m_cmp(k);
    out_ready = ~out_ready;
    #1;
    if (model_on) for (int k = 0; k < 3; k++) chk($sformatf("d%0d_ready_probe", k), irdy[k], m_irdy(k));
    out_ready = ~out_ready;
    #1;
    @(posedge clk);
    if (!rst_n) model_on = 1'b1;
    for (int k = 0; k < 3; k++) m_step(k);
    #1;
  endtask

  typedef struct {
    logic        rst_n, flush, iv;
    logic [31:0] ctrl;
    logic        ordy, chk, ov;
    logic [31:0] octrl;
    logic        irdy;
    logic [1:0]  occ;
  } vec_t;

  vec_t tbl[31];

  function automatic vec_t v(logic r, logic f, logic iv, logic [31:0] c, logic ordy, logic ck,
                             logic ov_e, logic [31:0] oc, logic ir, logic [1:0] oc_n);
    vec_t t;
    t.rst_n = r; t.flush = f; t.iv = iv; t.ctrl = c; t.ordy = ordy; t.chk = ck;
    t.ov = ov_e; t.octrl = oc; t.irdy = ir; t.occ = oc_n;
    return t;
  endfunction

  initial begin
    //            rst fl iv ctrl ordy chk  ov  octrl irdy occ  (expected before the edge)
    tbl[0]  = v(0, 0, 1, 32'hA5, 1, 0, 0, 0, 1, 0);
    tbl[1]  = v(0, 0, 1, 32'hA5, 1, 1, 0, 0, 1, 0);
    tbl[2]  = v(0, 0, 1, 32'hA5, 1, 1, 0, 0, 1, 0);
    tbl[3]  = v(1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++)
      tbl[4+i] = v(1, 0, 1, 32'(i + 1), 1, 1, i != 0, (i == 0) ? 0 : 32'(i), 1, (i == 0) ? 0 : 1);
    tbl[12] = v(1, 0, 0, 0, 1, 1, 1, 8, 1, 1);
    tbl[13] = v(1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    tbl[14] = v(1, 0, 1, 5, 1, 1, 0, 0, 1, 0);
    tbl[15] = v(1, 0, 1, 6, 0, 1, 1, 5, 1, 1);
    tbl[16] = v(1, 0, 1, 7, 0, 1, 1, 5, 0, 2);
    tbl[17] = v(1, 0, 1, 7, 0, 1, 1, 5, 0, 2);
    tbl[18] = v(1, 0, 1, 7, 1, 1, 1, 5, 0, 2);
    tbl[19] = v(1, 0, 1, 7, 1, 1, 1, 6, 1, 1);
    tbl[20] = v(1, 0, 0, 0, 1, 1, 1, 7, 1, 1);
    tbl[21] = v(1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    tbl[22] = v(1, 0, 1, 9, 0, 1, 0, 0, 1, 0);
    tbl[23] = v(1, 0, 1, 10, 0, 1, 1, 9, 1, 1);
    tbl[24] = v(1, 1, 1, 11, 0, 1, 1, 9, 0, 2);
    tbl[25] = v(1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    tbl[26] = v(1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    tbl[27] = v(1, 0, 1, 12, 0, 1, 0, 0, 1, 0);
    tbl[28] = v(1, 0, 1, 13, 0, 1, 1, 12, 1, 1);
    tbl[29] = v(0, 1, 1, 14, 0, 1, 1, 12, 0, 2);
    tbl[30] = v(1, 0, 0, 0, 1, 1, 0, 0, 1, 0);

    for (int i = 0; i < 31; i++) begin
      rst_n = tbl[i].rst_n; flush = tbl[i].flush; in_valid = tbl[i].iv;
      in_ctrl = tbl[i].ctrl; in_data = mk_data(tbl[i].ctrl); out_ready = tbl[i].ordy;
      #1;
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_out_valid", i), ov[0], tbl[i].ov);
        chk($sformatf("tbl%0d_out_ctrl", i), octrl[0], tbl[i].octrl);
        chk($sformatf("tbl%0d_in_ready", i), irdy[0], tbl[i].irdy);
        chk($sformatf("tbl%0d_occupancy", i), occ[0], tbl[i].occ);
        if (tbl[i].ov) chk($sformatf("tbl%0d_out_data", i), odata[0], mk_data(tbl[i].octrl));
      end
      // Reset with two entries held: the no-clear build keeps the head data but drops valid.
      if (i == 30) begin
        chk("nc_reset_valid", ov[2], 1'b0);
        chk("nc_reset_data_held", odata[2], mk_data(32'd12));
      end
      cycle();
    end

    // Single-entry build: in_ready follows out_ready combinationally while full.
    in_valid = 1'b1; in_ctrl = 32'h77; in_data = mk_data(32'h77); out_ready = 1'b0;
    #1;
    cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("s0_in_ready_stalled", irdy[1], 1'b0);
    chk("s1_in_ready_stalled", irdy[0], 1'b1);
    out_ready = 1'b1;
    #1;
    chk("s0_in_ready_follows", irdy[1], 1'b1);
    chk("s1_in_ready_steady", irdy[0], 1'b1);
    cycle();

    for (int c = 0; c < 10000; c++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      flush     = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_ctrl   = $urandom;
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
